time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, clock frequency in Hz; sets the blink and timeout dividers.
REQ-002 SHALL have parameter TIMEOUT_S, default 30, seconds without a button edge before an edit is abandoned.
REQ-003 SHALL have port clk_50M  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports btn_mode, btn_inc, btn_dec  input  1 each  debounced, active-high button levels.
REQ-006 SHALL have ports cur_hour_chuc, cur_hour_dv, cur_min_chuc, cur_min_dv, cur_sec_chuc, cur_sec_dv  input  4 each  running time in BCD.
REQ-007 SHALL have ports set_hour_chuc, set_hour_dv, set_min_chuc, set_min_dv, set_sec_chuc, set_sec_dv  output  4 each  edited time in BCD.
REQ-008 SHALL have port set_active  output  1  high in every edit state; the timekeeper freezes while it is high.
REQ-009 SHALL have port load  output  1  one-cycle pulse; the timekeeper copies set_* on this pulse.
REQ-010 SHALL have port blank_mask  output  3  {hour,min,sec} digit-pair blank request for the display driver.
REQ-011 SHALL have port field  output  2  current state: 0 RUN, 1 HOUR, 2 MIN, 3 SEC.

Function
REQ-012 SHALL detect rising edges of each button (registered previous level); only edges act, held levels are ignored.
REQ-013 SHALL implement FSM RUN -> HOUR -> MIN -> SEC -> COMMIT -> RUN; each arrow except COMMIT->RUN is taken on a mode edge.
REQ-014 SHALL leave COMMIT unconditionally after exactly one cycle; load = 1 only in COMMIT.
REQ-015 SHALL, on the RUN->HOUR transition, capture all six cur_* digits into shadow registers that drive set_*.
REQ-016 SHALL, in RUN, hold the shadow registers unchanged and ignore inc/dec.
REQ-017 SHALL, on an inc edge in HOUR, step hours 00..23 with 23 wrapping to 00; a dec edge steps down with 00 wrapping to 23.
REQ-018 SHALL, in MIN or SEC, step 00..59 with 59 wrapping to 00 on inc and 00 wrapping to 59 on dec.
REQ-019 SHALL keep every step in BCD: units digit rolls 9->0 and carries into tens; results are always valid BCD.
REQ-020 SHALL clear the seconds shadow to 00 on the MIN->SEC transition.
REQ-021 SHALL give priority mode > inc > dec when edges coincide in the same cycle.
REQ-022 SHALL ignore both inc and dec when they coincide without a mode edge.
REQ-023 SHALL assert set_active in HOUR, MIN, SEC and COMMIT, and deassert it in RUN.
REQ-024 SHALL toggle a blink phase every CLK_HZ/2 cycles, resetting the phase counter on every state change and every inc/dec edge.
REQ-025 SHALL drive blank_mask as the edited field's bit = blink phase, other bits 0, in an edit state; 000 in RUN.
REQ-026 SHALL count idle cycles in the edit states and clear the count on any button edge.
REQ-027 SHALL, when the idle count reaches TIMEOUT_S*CLK_HZ, return to RUN without load (edit abandoned).
REQ-028 SHALL size all divider counters as $clog2 of their terminal count plus one.

Reset
REQ-029 SHALL, while reset = 1, force state RUN, all shadow digits 0, load 0, set_active 0, blank_mask 000, field 0, counters and blink phase 0, and previous button levels 0.
REQ-030 SHALL let reset override all events in the same cycle, including mid-edit, with no load pulse emitted.

Structure
REQ-031 SHALL take the state encoding (RUN, HOUR, MIN, SEC, COMMIT) and the limits 23 and 59 from shared package clock_pkg.
REQ-032 SHALL use one sub-module, bcd_updown2, instantiated three times: a 2-digit BCD up/down counter with a max-value input and wrap.
REQ-033 SHALL contain no combinational path from inputs to load or set_active.

Verification (CLK_HZ=20, TIMEOUT_S=2 for speed)
REQ-034 SHALL check: cur=12:34:56; mode, 3 inc, mode, 1 dec, mode, mode -> load pulse once with set=15:33:00, then field=0.
REQ-035 SHALL check: HOUR=23 plus inc -> 00; MIN=00 plus dec -> 59; MIN=09 plus inc -> 10 (BCD carry).
REQ-036 SHALL check: inc and dec edges in the same cycle leave the shadow unchanged; mode and inc together advance the field and leave the value unchanged.
REQ-037 SHALL check: enter HOUR and idle for 40 cycles -> RUN with no load pulse.
REQ-038 SHALL check: reset asserted in MIN -> next cycle field=0, set_active=0, all set_* 0, no load pulse.
REQ-039 SHALL check: in HOUR, blank_mask=100 toggles every 10 cycles; holding btn_inc high for 50 cycles increments hours exactly once.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared state encoding, BCD limits and field helper for the time-setting controller.
package clock_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [2:0] state_t;

  localparam state_t ST_RUN    = 3'd0;
  localparam state_t ST_HOUR   = 3'd1;
  localparam state_t ST_MIN    = 3'd2;
  localparam state_t ST_SEC    = 3'd3;
  localparam state_t ST_COMMIT = 3'd4;

  localparam bcd_t HOUR_MAX_TENS  = 4'd2;
  localparam bcd_t HOUR_MAX_UNITS = 4'd3;
  localparam bcd_t MS_MAX_TENS    = 4'd5;
  localparam bcd_t MS_MAX_UNITS   = 4'd9;

  // One-hot {hour,min,sec} position of the field being edited in a given state.
  function automatic logic [2:0] field_mask(input state_t st);
    case (st)
      ST_HOUR: field_mask = 3'b100;
      ST_MIN:  field_mask = 3'b010;
      ST_SEC:  field_mask = 3'b001;
      default: field_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/bcd_updown2.sv
// Two-digit BCD up/down counter with parallel load, clear and wrap at a max value.
module bcd_updown2
  import clock_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  bcd_t load_tens,
  input  bcd_t load_units,
  input  logic clr,
  input  logic up,
  input  logic down,
  input  bcd_t max_tens,
  input  bcd_t max_units,
  output bcd_t tens,
  output bcd_t units
);

  logic at_max;
  logic at_zero;

  assign at_max  = (tens == max_tens) && (units == max_units);
  assign at_zero = (tens == 4'd0) && (units == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (load) begin
      tens  <= load_tens;
      units <= load_units;
    end else if (clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (up) begin
      if (at_max) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= 4'd0;
      end else begin
        units <= units + 4'd1;
      end
    end else if (down) begin
      if (at_zero) begin
        tens  <= max_tens;
        units <= max_units;
      end else if (units == 4'd0) begin
        tens  <= tens - 4'd1;
        units <= 4'd9;
      end else begin
        units <= units - 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: captures running time, edits h/m/s in BCD,
// and hands the result back to the timekeeper with a one-cycle load pulse.
//
// state  | meaning
// RUN    | clock running, shadow held, buttons except mode ignored
// HOUR   | editing hours (00..23)
// MIN    | editing minutes (00..59)
// SEC    | editing seconds (00..59), cleared on entry
// COMMIT | one-cycle load pulse, then back to RUN
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [3:0] cur_hour_chuc,
  input  logic [3:0] cur_hour_dv,
  input  logic [3:0] cur_min_chuc,
  input  logic [3:0] cur_min_dv,
  input  logic [3:0] cur_sec_chuc,
  input  logic [3:0] cur_sec_dv,
  output logic [3:0] set_hour_chuc,
  output logic [3:0] set_hour_dv,
  output logic [3:0] set_min_chuc,
  output logic [3:0] set_min_dv,
  output logic [3:0] set_sec_chuc,
  output logic [3:0] set_sec_dv,
  output logic       set_active,
  output logic       load,
  output logic [2:0] blank_mask,
  output logic [1:0] field
);

  localparam int BLINK_TC   = CLK_HZ / 2 - 1;
  localparam int TIMEOUT_TC = TIMEOUT_S * CLK_HZ - 1;
  localparam int BLINK_W    = (BLINK_TC > 0) ? $clog2(BLINK_TC + 1) : 1;
  localparam int TO_W       = (TIMEOUT_TC > 0) ? $clog2(TIMEOUT_TC + 1) : 1;
  localparam logic [BLINK_W-1:0] BLINK_RELOAD = BLINK_W'(BLINK_TC);
  localparam logic [TO_W-1:0]    TO_RELOAD    = TO_W'(TIMEOUT_TC);

  state_t state;
  state_t state_nxt;

  logic mode_q, inc_q, dec_q;
  logic mode_e, inc_e, dec_e, any_e;
  logic inc_act, dec_act;
  logic edit;
  logic timeout;
  logic capture;
  logic clr_sec;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [TO_W-1:0]    idle_cnt;

  assign mode_e = btn_mode & ~mode_q;
  assign inc_e  = btn_inc  & ~inc_q;
  assign dec_e  = btn_dec  & ~dec_q;
  assign any_e  = mode_e | inc_e | dec_e;

  // Mode wins over everything; simultaneous inc and dec cancel each other.
  assign inc_act = inc_e & ~dec_e & ~mode_e;
  assign dec_act = dec_e & ~inc_e & ~mode_e;

  assign edit    = (state == ST_HOUR) || (state == ST_MIN) || (state == ST_SEC);
  assign timeout = edit && !any_e && (idle_cnt == '0);
  assign capture = (state == ST_RUN) && mode_e;
  assign clr_sec = (state == ST_MIN) && mode_e;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (mode_e) state_nxt = ST_HOUR;
      ST_HOUR:   if (mode_e) state_nxt = ST_MIN;    else if (timeout) state_nxt = ST_RUN;
      ST_MIN:    if (mode_e) state_nxt = ST_SEC;    else if (timeout) state_nxt = ST_RUN;
      ST_SEC:    if (mode_e) state_nxt = ST_COMMIT; else if (timeout) state_nxt = ST_RUN;
      ST_COMMIT: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state  <= ST_RUN;
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
      dec_q  <= btn_dec;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!edit || (state_nxt != state) || inc_e || dec_e) begin
      blink_cnt   <= BLINK_RELOAD;
      blink_phase <= 1'b0;
    end else if (blink_cnt == '0) begin
      blink_cnt   <= BLINK_RELOAD;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!edit || any_e) begin
      idle_cnt <= TO_RELOAD;
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  bcd_updown2 u_hour (
    .clk        (clk_50M),
    .reset      (reset),
    .load       (capture),
    .load_tens  (cur_hour_chuc),
    .load_units (cur_hour_dv),
    .clr        (1'b0),
    .up         ((state == ST_HOUR) && inc_act),
    .down       ((state == ST_HOUR) && dec_act),
    .max_tens   (HOUR_MAX_TENS),
    .max_units  (HOUR_MAX_UNITS),
    .tens       (set_hour_chuc),
    .units      (set_hour_dv)
  );

  bcd_updown2 u_min (
    .clk        (clk_50M),
    .reset      (reset),
    .load       (capture),
    .load_tens  (cur_min_chuc),
    .load_units (cur_min_dv),
    .clr        (1'b0),
    .up         ((state == ST_MIN) && inc_act),
    .down       ((state == ST_MIN) && dec_act),
    .max_tens   (MS_MAX_TENS),
    .max_units  (MS_MAX_UNITS),
    .tens       (set_min_chuc),
    .units      (set_min_dv)
  );

  bcd_updown2 u_sec (
    .clk        (clk_50M),
    .reset      (reset),
    .load       (capture),
    .load_tens  (cur_sec_chuc),
    .load_units (cur_sec_dv),
    .clr        (clr_sec),
    .up         ((state == ST_SEC) && inc_act),
    .down       ((state == ST_SEC) && dec_act),
    .max_tens   (MS_MAX_TENS),
    .max_units  (MS_MAX_UNITS),
    .tens       (set_sec_chuc),
    .units      (set_sec_dv)
  );

  // All outputs decode the state register only, so no input reaches them combinationally.
  assign load       = (state == ST_COMMIT);
  assign set_active = (state != ST_RUN);
  assign field      = edit ? state[1:0] : 2'd0;
  assign blank_mask = field_mask(state) & {3{blink_phase}};

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl with a 20 Hz clock and 2 s timeout.
module tb_time_set_ctrl;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_dec;
  logic [3:0] cur_hour_chuc, cur_hour_dv, cur_min_chuc, cur_min_dv, cur_sec_chuc, cur_sec_dv;
  logic [3:0] set_hour_chuc, set_hour_dv, set_min_chuc, set_min_dv, set_sec_chuc, set_sec_dv;
  logic       set_active, load;
  logic [2:0] blank_mask;
  logic [1:0] field;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          load_cnt = 0;
  logic [23:0] load_val = '0;

  time_set_ctrl #(.CLK_HZ(20), .TIMEOUT_S(2)) dut (
    .clk_50M(clk_50M), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hour_chuc(cur_hour_chuc), .cur_hour_dv(cur_hour_dv),
    .cur_min_chuc(cur_min_chuc), .cur_min_dv(cur_min_dv),
    .cur_sec_chuc(cur_sec_chuc), .cur_sec_dv(cur_sec_dv),
    .set_hour_chuc(set_hour_chuc), .set_hour_dv(set_hour_dv),
    .set_min_chuc(set_min_chuc), .set_min_dv(set_min_dv),
    .set_sec_chuc(set_sec_chuc), .set_sec_dv(set_sec_dv),
    .set_active(set_active), .load(load), .blank_mask(blank_mask), .field(field)
  );

  always #5 clk_50M = ~clk_50M;

  always @(negedge clk_50M) begin
    if (load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      load_val <= set_val();
    end
  end

  function automatic logic [23:0] set_val();
    return {set_hour_chuc, set_hour_dv, set_min_chuc, set_min_dv, set_sec_chuc, set_sec_dv};
  endfunction

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic set_cur(input logic [23:0] t);
    {cur_hour_chuc, cur_hour_dv, cur_min_chuc, cur_min_dv, cur_sec_chuc, cur_sec_dv} = t;
  endtask

  task automatic do_reset();
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press(input bit m, input bit i, input bit d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    tick();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    set_cur(24'h123456);
    do_reset();
    chk_cnt++; if (field !== 2'd0) $display("FAIL reset_field got %0d want 0", field); else pass_cnt++;
    chk_cnt++; if (set_val() !== 24'h000000) $display("FAIL reset_set got %h want 000000", set_val()); else pass_cnt++;
    chk_cnt++; if ({set_active, load, blank_mask} !== 5'b0) $display("FAIL reset_ctrl got %b want 00000", {set_active, load, blank_mask}); else pass_cnt++;
  endtask

  task automatic test_edit_flow();
    int base;
    base = load_cnt;
    set_cur(24'h123456);
    do_reset();
    press(1, 0, 0);
    chk_cnt++; if (field !== 2'd1) $display("FAIL flow_hour_field got %0d want 1", field); else pass_cnt++;
    chk_cnt++; if (set_val() !== 24'h123456) $display("FAIL flow_capture got %h want 123456", set_val()); else pass_cnt++;
    chk_cnt++; if (set_active !== 1'b1) $display("FAIL flow_active got %b want 1", set_active); else pass_cnt++;
    for (int k = 0; k < 3; k++) press(0, 1, 0);
    chk_cnt++; if (set_val() !== 24'h153456) $display("FAIL flow_inc3 got %h want 153456", set_val()); else pass_cnt++;
    press(1, 0, 0);
    press(0, 0, 1);
    chk_cnt++; if (set_val() !== 24'h153356) $display("FAIL flow_min_dec got %h want 153356", set_val()); else pass_cnt++;
    press(1, 0, 0);
    chk_cnt++; if (set_val() !== 24'h153300) $display("FAIL flow_sec_clear got %h want 153300", set_val()); else pass_cnt++;
    chk_cnt++; if (load_cnt - base !== 0) $display("FAIL flow_early_load got %0d want 0", load_cnt - base); else pass_cnt++;
    press(1, 0, 0);
    chk_cnt++; if (load_cnt - base !== 1) $display("FAIL flow_load_count got %0d want 1", load_cnt - base); else pass_cnt++;
    chk_cnt++; if (load_val !== 24'h153300) $display("FAIL flow_load_value got %h want 153300", load_val); else pass_cnt++;
    chk_cnt++; if ({field, set_active} !== 3'b000) $display("FAIL flow_back_run got %b want 000", {field, set_active}); else pass_cnt++;
  endtask

  task automatic test_wrap();
    set_cur(24'h230000);
    do_reset();
    press(1, 0, 0);
    press(0, 1, 0);
    chk_cnt++; if (set_val() !== 24'h000000) $display("FAIL wrap_hour_up got %h want 000000", set_val()); else pass_cnt++;
    press(0, 0, 1);
    chk_cnt++; if (set_val() !== 24'h230000) $display("FAIL wrap_hour_down got %h want 230000", set_val()); else pass_cnt++;
    press(1, 0, 0);
    press(0, 0, 1);
    chk_cnt++; if (set_val() !== 24'h235900) $display("FAIL wrap_min_down got %h want 235900", set_val()); else pass_cnt++;
    press(0, 1, 0);
    chk_cnt++; if (set_val() !== 24'h230000) $display("FAIL wrap_min_up got %h want 230000", set_val()); else pass_cnt++;
    for (int k = 0; k < 9; k++) press(0, 1, 0);
    chk_cnt++; if (set_val() !== 24'h230900) $display("FAIL wrap_min_09 got %h want 230900", set_val()); else pass_cnt++;
    press(0, 1, 0);
    chk_cnt++; if (set_val() !== 24'h231000) $display("FAIL wrap_bcd_carry got %h want 231000", set_val()); else pass_cnt++;
    press(1, 0, 0);
    press(0, 0, 1);
    chk_cnt++; if (set_val() !== 24'h231059) $display("FAIL wrap_sec_down got %h want 231059", set_val()); else pass_cnt++;
  endtask

  task automatic test_coincident();
    set_cur(24'h123456);
    do_reset();
    press(1, 0, 0);
    press(0, 1, 1);
    chk_cnt++; if ({field, set_val()} !== {2'd1, 24'h123456}) $display("FAIL coinc_inc_dec got %0d/%h want 1/123456", field, set_val()); else pass_cnt++;
    press(1, 1, 0);
    chk_cnt++; if ({field, set_val()} !== {2'd2, 24'h123456}) $display("FAIL coinc_mode_inc got %0d/%h want 2/123456", field, set_val()); else pass_cnt++;
    press(0, 0, 1);
    chk_cnt++; if (set_val() !== 24'h123356) $display("FAIL coinc_after got %h want 123356", set_val()); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int base;
    base = load_cnt;
    set_cur(24'h081522);
    do_reset();
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    chk_cnt++; if (field !== 2'd1) $display("FAIL to_enter got %0d want 1", field); else pass_cnt++;
    repeat (39) tick();
    chk_cnt++; if (field !== 2'd1) $display("FAIL to_before got %0d want 1", field); else pass_cnt++;
    tick();
    chk_cnt++; if ({field, set_active} !== 3'b000) $display("FAIL to_expired got %b want 000", {field, set_active}); else pass_cnt++;
    chk_cnt++; if (load_cnt - base !== 0) $display("FAIL to_no_load got %0d want 0", load_cnt - base); else pass_cnt++;
  endtask

  task automatic test_reset_mid_edit();
    int base;
    base = load_cnt;
    set_cur(24'h123456);
    do_reset();
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    chk_cnt++; if ({field, set_val()} !== {2'd2, 24'h123556}) $display("FAIL rst_pre got %0d/%h want 2/123556", field, set_val()); else pass_cnt++;
    reset = 1'b1;
    btn_mode = 1'b1;
    tick();
    reset = 1'b0;
    btn_mode = 1'b0;
    chk_cnt++; if ({field, set_active, blank_mask} !== 6'b0) $display("FAIL rst_ctrl got %b want 000000", {field, set_active, blank_mask}); else pass_cnt++;
    chk_cnt++; if (set_val() !== 24'h000000) $display("FAIL rst_set got %h want 000000", set_val()); else pass_cnt++;
    repeat (3) tick();
    chk_cnt++; if (load_cnt - base !== 0) $display("FAIL rst_no_load got %0d want 0", load_cnt - base); else pass_cnt++;
  endtask

  task automatic test_blink_hold();
    int base;
    base = load_cnt;
    set_cur(24'h123456);
    do_reset();
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    chk_cnt++; if (blank_mask !== 3'b000) $display("FAIL blink_t0 got %b want 000", blank_mask); else pass_cnt++;
    repeat (9) tick();
    chk_cnt++; if (blank_mask !== 3'b000) $display("FAIL blink_t9 got %b want 000", blank_mask); else pass_cnt++;
    tick();
    chk_cnt++; if (blank_mask !== 3'b100) $display("FAIL blink_t10 got %b want 100", blank_mask); else pass_cnt++;
    repeat (10) tick();
    chk_cnt++; if (blank_mask !== 3'b000) $display("FAIL blink_t20 got %b want 000", blank_mask); else pass_cnt++;
    repeat (10) tick();
    chk_cnt++; if (blank_mask !== 3'b100) $display("FAIL blink_t30 got %b want 100", blank_mask); else pass_cnt++;
    btn_inc = 1'b1;
    tick();
    chk_cnt++; if ({blank_mask, set_val()} !== {3'b000, 24'h133456}) $display("FAIL hold_edge got %b/%h want 000/133456", blank_mask, set_val()); else pass_cnt++;
    repeat (49) tick();
    btn_inc = 1'b0;
    chk_cnt++; if (set_val() !== 24'h133456) $display("FAIL hold_once got %h want 133456", set_val()); else pass_cnt++;
    chk_cnt++; if ({field, load_cnt - base} !== {2'd0, 32'sd0}) $display("FAIL hold_timeout got %0d/%0d want 0/0", field, load_cnt - base); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    set_cur(24'h000000);
    test_reset();
    test_edit_flow();
    test_wrap();
    test_coincident();
    test_timeout();
    test_reset_mid_edit();
    test_blink_hold();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
